// File: rtl/aes128_reg_if.sv
// ---------------------------------------------------------------------------
// aes128_reg_if
// CPU register front-end for the AES-128 core. 32-bit bus writes assemble the
// 128-bit key and data words, a CTRL write issues a single-cycle start (with
// the operation code) to the core, and the core's result is captured into a
// read-only RESULT register on a fresh rising edge of the core's valid level.
// A sticky done flag, a sticky error flag and a level interrupt are exposed.
//
// Bus handshake: a write is accepted in the cycle wr_i is high. A read is
// requested by holding rd_i high for one cycle. rdata_o/rvalid_o are then
// presented exactly one cycle later with no back-pressure. If rd_i and wr_i
// are both high, the write takes effect and the read returns the value the
// register held before that write.
//
// Register map (word n of a 128-bit register = bits [32n+31:32n]):
//   0-3   KEY     RW
//   4-7   DATA    RW
//   8-11  RESULT  RO
//   12    CTRL    WO  bit0 start, bits2:1 op
//   13    STATUS      bit0 ready (RO), bit1 done (W1C), bit2 err (W1C)
//   14    IRQEN   RW  bit0
//   other         reads return 0, writes ignored
// ---------------------------------------------------------------------------
module aes128_reg_if #(
    parameter logic IRQ_EN_RST = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    // CPU bus
    input  logic [3:0]   addr_i,
    input  logic [31:0]  wdata_i,
    input  logic         wr_i,
    input  logic         rd_i,
    output logic [31:0]  rdata_o,
    output logic         rvalid_o,
    output logic         irq_o,
    // AES core
    output logic         aes_start_o,
    output logic [1:0]   aes_op_o,
    output logic [127:0] aes_key_o,
    output logic [127:0] aes_data_o,
    input  logic [127:0] aes_result_i,
    input  logic         aes_valid_i,
    input  logic         aes_ready_i,
    // Debug view of the control FSM (0=IDLE, 1=ISSUE, 2=BUSY)
    output logic [1:0]   dbg_state_o
);

    // Word addresses of the single-word registers
    localparam logic [3:0] ADDR_CTRL   = 4'd12;
    localparam logic [3:0] ADDR_STATUS = 4'd13;
    localparam logic [3:0] ADDR_IRQEN  = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t         r_state;
    logic [127:0]   r_key;
    logic [127:0]   r_data;
    logic [127:0]   r_result;
    logic [1:0]     r_op;
    logic           r_start;
    logic           r_done;
    logic           r_err;
    logic           r_irq_en;
    logic           r_valid_d;
    logic [31:0]    r_rdata;
    logic           r_rvalid;

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    logic           w_idle;
    logic           w_wr_key;
    logic           w_wr_data;
    logic           w_wr_ctrl;
    logic           w_wr_status;
    logic           w_wr_irqen;
    logic           w_start_req;
    logic           w_start_acc;
    logic           w_cfg_blocked;
    logic           w_err_set;
    logic           w_err_clr;
    logic           w_done_clr;
    logic           w_valid_rise;
    logic           w_capture;
    logic           w_ready;
    logic [6:0]     w_word_lsb;
    logic [31:0]    w_rd_word;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_wr_key      = wr_i && (addr_i[3:2] == 2'b00);
    assign w_wr_data     = wr_i && (addr_i[3:2] == 2'b01);
    assign w_wr_ctrl     = wr_i && (addr_i == ADDR_CTRL);
    assign w_wr_status   = wr_i && (addr_i == ADDR_STATUS);
    assign w_wr_irqen    = wr_i && (addr_i == ADDR_IRQEN);

    // A start request is only honoured from IDLE; anywhere else it is an error
    assign w_start_req   = w_wr_ctrl && wdata_i[0];
    assign w_start_acc   = w_start_req && w_idle;

    // Key/data must stay stable to the core while an operation is in flight
    assign w_cfg_blocked = (w_wr_key || w_wr_data || w_wr_irqen) && !w_idle;
    assign w_err_set     = (w_start_req && !w_idle) || w_cfg_blocked;
    assign w_err_clr     = w_wr_status && wdata_i[2];
    assign w_done_clr    = w_wr_status && wdata_i[1];

    // Only a 0->1 transition seen while BUSY counts as a new result; a valid
    // level left over from the previous operation is ignored.
    assign w_valid_rise  = aes_valid_i && !r_valid_d;
    assign w_capture     = (r_state == ST_BUSY) && w_valid_rise;

    assign w_ready       = w_idle && aes_ready_i;

    // Bit offset of the 32-bit word selected inside a 128-bit register
    assign w_word_lsb    = {addr_i[1:0], 5'b00000};

    // -----------------------------------------------------------------------
    // Control FSM: IDLE -> ISSUE (wait for core ready) -> BUSY (wait result)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
            r_op    <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_start <= 1'b0;
                    if (w_start_acc) begin
                        r_op    <= wdata_i[2:1];
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (aes_ready_i) begin
                        r_start <= 1'b1;
                        r_state <= ST_BUSY;
                    end else begin
                        r_start <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    r_start <= 1'b0;
                    if (w_capture) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_start <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered copy of the core valid level for edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid_d <= 1'b0;
        end else begin
            r_valid_d <= aes_valid_i;
        end
    end

    // KEY words: writable only while idle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_key <= '0;
        end else if (w_wr_key && w_idle) begin
            r_key[w_word_lsb +: 32] <= wdata_i;
        end
    end

    // DATA words: writable only while idle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data <= '0;
        end else if (w_wr_data && w_idle) begin
            r_data[w_word_lsb +: 32] <= wdata_i;
        end
    end

    // IRQ enable: writable only while idle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_irq_en <= IRQ_EN_RST;
        end else if (w_wr_irqen && w_idle) begin
            r_irq_en <= wdata_i[0];
        end
    end

    // RESULT holds the last captured value until the next capture
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_result <= '0;
        end else if (w_capture) begin
            r_result <= aes_result_i;
        end
    end

    // Sticky done: a capture in the same cycle as a W1C clear wins
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_done <= 1'b0;
        end else if (w_capture) begin
            r_done <= 1'b1;
        end else if (w_done_clr) begin
            r_done <= 1'b0;
        end
    end

    // Sticky err: a new error in the same cycle as a W1C clear wins
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (w_err_clr) begin
            r_err <= 1'b0;
        end
    end

    // Read mux over the current (pre-write) register contents
    always_comb begin
        w_rd_word = '0;
        case (addr_i)
            4'd0, 4'd1, 4'd2, 4'd3:   w_rd_word = r_key[w_word_lsb +: 32];
            4'd4, 4'd5, 4'd6, 4'd7:   w_rd_word = r_data[w_word_lsb +: 32];
            4'd8, 4'd9, 4'd10, 4'd11: w_rd_word = r_result[w_word_lsb +: 32];
            ADDR_STATUS:              w_rd_word = {29'd0, r_err, r_done, w_ready};
            ADDR_IRQEN:               w_rd_word = {31'd0, r_irq_en};
            default:                  w_rd_word = '0;
        endcase
    end

    // Registered read port: one-cycle latency, data held between reads
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= rd_i;
            if (rd_i) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign rdata_o     = r_rdata;
    assign rvalid_o    = r_rvalid;
    assign irq_o       = r_done && r_irq_en;
    assign aes_start_o = r_start;
    assign aes_op_o    = r_op;
    assign aes_key_o   = r_key;
    assign aes_data_o  = r_data;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_aes128_reg_if.sv
// ---------------------------------------------------------------------------
// tb_aes128_reg_if
// Directed bench for aes128_reg_if with a behavioural AES core stub. Bus reads
// push their expected word into exp_q; a monitor pops and compares whenever
// rvalid_o is seen. Start pulses are counted by the same monitor.
// ---------------------------------------------------------------------------
module tb_aes128_reg_if;

    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] DATA = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] R1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] R2   = 128'h11112222333344445555666677778888;
    localparam logic [127:0] R3   = 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;
    localparam logic [127:0] R4   = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] R5   = 128'hcafef00d12345678deadc0de87654321;
    localparam logic [127:0] JUNK = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;

    // ---------------- clock / reset / DUT signals ----------------
    logic         clk_i   = 1'b0;
    logic         rst_n_i = 1'b0;
    logic [3:0]   addr_i  = '0;
    logic [31:0]  wdata_i = '0;
    logic         wr_i    = 1'b0;
    logic         rd_i    = 1'b0;
    logic [31:0]  rdata_o;
    logic         rvalid_o;
    logic         irq_o;
    logic         aes_start_o;
    logic [1:0]   aes_op_o;
    logic [127:0] aes_key_o;
    logic [127:0] aes_data_o;
    logic [127:0] aes_result_i = '0;
    logic         aes_valid_i  = 1'b0;
    logic         aes_ready_i;
    logic [1:0]   dbg_state_o;

    always #5 clk_i = ~clk_i;

    aes128_reg_if #(.IRQ_EN_RST(1'b0)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .wr_i         (wr_i),
        .rd_i         (rd_i),
        .rdata_o      (rdata_o),
        .rvalid_o     (rvalid_o),
        .irq_o        (irq_o),
        .aes_start_o  (aes_start_o),
        .aes_op_o     (aes_op_o),
        .aes_key_o    (aes_key_o),
        .aes_data_o   (aes_data_o),
        .aes_result_i (aes_result_i),
        .aes_valid_i  (aes_valid_i),
        .aes_ready_i  (aes_ready_i),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    int          start_cnt = 0;
    logic [1:0]  last_op   = '0;
    int          s0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- AES core stub ----------------
    // Drops ready while busy, returns stub_result stub_lat cycles after start.
    // With keep_valid set, a stale valid level is left high after start and
    // only dropped for one cycle right before the new result appears.
    int           stub_lat    = 20;
    logic [127:0] stub_result = R1;
    logic         hold_ready  = 1'b0;
    logic         keep_valid  = 1'b0;
    logic         core_busy   = 1'b0;
    int           stub_cnt    = 0;

    assign aes_ready_i = !core_busy && !hold_ready;

    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                core_busy   = 1'b0;
                aes_valid_i = 1'b0;
                stub_cnt    = 0;
            end else if (aes_start_o) begin
                core_busy    = 1'b1;
                stub_cnt     = stub_lat;
                aes_result_i = JUNK;
                if (!keep_valid) aes_valid_i = 1'b0;
            end else if (core_busy) begin
                if (stub_cnt <= 1) begin
                    aes_valid_i  = 1'b1;
                    aes_result_i = stub_result;
                    core_busy    = 1'b0;
                    stub_cnt     = 0;
                end else begin
                    if (stub_cnt == 2) aes_valid_i = 1'b0;
                    stub_cnt = stub_cnt - 1;
                end
            end
        end
    end

    // ---------------- monitor: read data and start pulses ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            if (rvalid_o) begin
                if (exp_q.size() == 0) chk("rvalid_unexpected", 1'b1, 1'b0);
                else                   chk("rdata", rdata_o, exp_q.pop_front());
            end
            if (aes_start_o) begin
                start_cnt++;
                last_op = aes_op_o;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk_i);
        addr_i  = a;
        wdata_i = d;
        wr_i    = 1'b1;
        @(negedge clk_i);
        wr_i    = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] e);
        @(negedge clk_i);
        addr_i = a;
        rd_i   = 1'b1;
        exp_q.push_back(e);
        @(negedge clk_i);
        rd_i   = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int max_cyc, input string tag);
        int n = 0;
        while (dbg_state_o !== s && n < max_cyc) begin
            @(negedge clk_i);
            n++;
        end
        chk(tag, dbg_state_o, s);
    endtask

    task automatic read_result(input logic [127:0] r);
        for (int i = 0; i < 4; i++) bus_read(4'(8 + i), r[32*i +: 32]);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_start", aes_start_o, 1'b0);
        chk("rst_op", aes_op_o, 2'd0);
        chk("rst_irq", irq_o, 1'b0);
        chk("rst_rvalid", rvalid_o, 1'b0);
        chk("rst_key", aes_key_o, 128'd0);
        chk("rst_state", dbg_state_o, S_IDLE);
        rst_n_i = 1'b1;
        bus_read(4'd13, 32'h1);
        bus_read(4'd14, 32'h0);

        // Encrypt with the known-answer vector, IRQ disabled
        for (int i = 0; i < 4; i++) bus_write(4'(i), KEY[32*i +: 32]);
        bus_write(4'd4, 32'h12345678);
        for (int i = 1; i < 4; i++) bus_write(4'(4 + i), DATA[32*i +: 32]);
        // Simultaneous read and write of DATA0: read sees the old value
        @(negedge clk_i);
        addr_i  = 4'd4;
        wdata_i = DATA[31:0];
        wr_i    = 1'b1;
        rd_i    = 1'b1;
        exp_q.push_back(32'h12345678);
        @(negedge clk_i);
        wr_i = 1'b0;
        rd_i = 1'b0;
        chk("t2_key", aes_key_o, KEY);
        chk("t2_data", aes_data_o, DATA);
        bus_read(4'd0, KEY[31:0]);
        bus_read(4'd7, DATA[127:96]);
        stub_result = R1;
        s0 = start_cnt;
        bus_write(4'd12, 32'h1);
        wait_state(S_IDLE, 100, "t2_done_wait");
        chk("t2_starts", start_cnt - s0, 1);
        chk("t2_op", last_op, 2'd0);
        read_result(R1);
        bus_read(4'd13, 32'h3);
        chk("t2_irq_off", irq_o, 1'b0);
        bus_write(4'd14, 32'h1);
        chk("t2_irq_on", irq_o, 1'b1);
        bus_read(4'd14, 32'h1);
        bus_write(4'd13, 32'h2);
        chk("t2_irq_clr", irq_o, 1'b0);
        bus_read(4'd13, 32'h1);
        bus_read(4'd12, 32'h0);

        // Core not ready: start held off, then one decrypt pulse
        hold_ready  = 1'b1;
        stub_result = R2;
        s0 = start_cnt;
        bus_write(4'd12, 32'h3);
        repeat (5) @(negedge clk_i);
        chk("t3_held_state", dbg_state_o, S_ISSUE);
        chk("t3_held_starts", start_cnt - s0, 0);
        hold_ready = 1'b0;
        wait_state(S_IDLE, 100, "t3_done_wait");
        chk("t3_starts", start_cnt - s0, 1);
        chk("t3_op", last_op, 2'd1);
        chk("t3_op_held", aes_op_o, 2'd1);
        repeat (5) @(negedge clk_i);
        chk("t3_no_second", start_cnt - s0, 1);
        bus_read(4'd8, R2[31:0]);
        bus_read(4'd13, 32'h3);
        chk("t3_irq", irq_o, 1'b1);

        // Writes while BUSY are rejected and flag err
        stub_result = R3;
        s0 = start_cnt;
        bus_write(4'd12, 32'h1);
        wait_state(S_BUSY, 20, "t4_busy_wait");
        bus_write(4'd12, 32'h5);
        bus_write(4'd0, 32'hdeadbeef);
        bus_read(4'd13, 32'h6);
        chk("t4_key_kept", aes_key_o, KEY);
        chk("t4_op_kept", aes_op_o, 2'd0);
        bus_write(4'd13, 32'h4);
        bus_read(4'd13, 32'h2);
        wait_state(S_IDLE, 100, "t4_done_wait");
        chk("t4_starts", start_cnt - s0, 1);
        bus_read(4'd0, KEY[31:0]);
        bus_read(4'd8, R3[31:0]);

        // done W1C in the same cycle as the capture: set wins
        bus_write(4'd13, 32'h2);
        stub_result = R4;
        bus_write(4'd12, 32'h1);
        begin
            int n = 0;
            do begin
                @(posedge clk_i);
                n++;
            end while (!(core_busy && stub_cnt == 1) && n < 200);
            chk("t5_sync", core_busy && stub_cnt == 1, 1'b1);
        end
        bus_write(4'd13, 32'h2);
        wait_state(S_IDLE, 10, "t5_done_wait");
        bus_read(4'd13, 32'h3);
        bus_read(4'd8, R4[31:0]);

        // Back-to-back op with stale valid left high: capture only on new edge
        bus_write(4'd13, 32'h2);
        keep_valid  = 1'b1;
        stub_result = R5;
        s0 = start_cnt;
        bus_write(4'd12, 32'h1);
        wait_state(S_BUSY, 20, "t6_busy_wait");
        repeat (5) @(negedge clk_i);
        chk("t6_stale_ignored", dbg_state_o, S_BUSY);
        bus_read(4'd8, R4[31:0]);
        bus_read(4'd13, 32'h0);
        wait_state(S_IDLE, 100, "t6_done_wait");
        keep_valid = 1'b0;
        chk("t6_starts", start_cnt - s0, 1);
        read_result(R5);
        chk("t6_irq", irq_o, 1'b1);

        // Asynchronous reset in the middle of an operation
        bus_write(4'd12, 32'h3);
        wait_state(S_BUSY, 20, "t7_busy_wait");
        bus_read(4'd9, R5[63:32]);
        #3;
        rst_n_i = 1'b0;
        #1;
        chk("t7_rst_start", aes_start_o, 1'b0);
        chk("t7_rst_op", aes_op_o, 2'd0);
        chk("t7_rst_key", aes_key_o, 128'd0);
        chk("t7_rst_data", aes_data_o, 128'd0);
        chk("t7_rst_irq", irq_o, 1'b0);
        chk("t7_rst_rdata", rdata_o, 32'd0);
        chk("t7_rst_rvalid", rvalid_o, 1'b0);
        chk("t7_rst_state", dbg_state_o, S_IDLE);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        addr_i = 4'd15;
        rd_i   = 1'b1;
        exp_q.push_back(32'h0);
        @(negedge clk_i);
        rd_i = 1'b0;
        chk("t7_rvalid_lat", rvalid_o, 1'b1);
        @(negedge clk_i);
        chk("t7_rvalid_drop", rvalid_o, 1'b0);
        bus_read(4'd13, 32'h1);
        bus_read(4'd14, 32'h0);
        bus_read(4'd8, 32'h0);
        bus_write(4'd15, 32'hffffffff);
        bus_read(4'd15, 32'h0);
        repeat (25) @(negedge clk_i);
        chk("t7_no_start_after_rst", start_cnt - s0, 2);

        repeat (2) @(negedge clk_i);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
